// File: rtl/lv1_lv2_bus_arbiter.sv
// Round-robin arbiter for the shared lv1-lv2 bus: a processor owner holds the bus, snoop/L2 sub-grants nest inside its tenure.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module lv1_lv2_bus_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_ID_WID    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WID    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
    input  logic                   bus_lv1_lv2_req_lv2,
    output logic                   bus_lv1_lv2_gnt_lv2,
    output logic                   bus_busy,
    output logic [CORE_ID_WID-1:0] owner_id,
    output logic                   err_timeout,
    output logic [1:0]             dbg_state_o
);

    // Handshake: a request is a level held by the requester; the grant is registered and stays
    // asserted while that level stays high. Dropping the level releases the grant one cycle later.
    typedef enum logic [1:0] {IDLE, PROC, SUB_SNOOP, SUB_LV2} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   gnt_proc_q, gnt_proc_d, gnt_snoop_q, gnt_snoop_d;
    logic                   gnt_lv2_q, gnt_lv2_d, busy_q, busy_d, rel_q, rel_d;
    logic [CORE_ID_WID-1:0] owner_q, owner_d, proc_ptr_q, proc_ptr_d, snoop_ptr_q, snoop_ptr_d;
    logic [CORE_ID_WID:0]   proc_pick, snoop_pick;
    logic                   owner_req, sub_req, tmo_fire;

    // Returns {found, index} of the first set bit strictly after ptr, wrapping.
    function automatic logic [CORE_ID_WID:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                     input logic [CORE_ID_WID-1:0] ptr);
        logic                   found;
        logic [CORE_ID_WID-1:0] idx;
        int                     pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            pos = (int'(ptr) + k) % NUM_CORES;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = CORE_ID_WID'(pos);
            end
        end
        return {found, idx};
    endfunction

    assign proc_pick  = rr_pick(bus_lv1_lv2_req_proc, proc_ptr_q);
    assign snoop_pick = rr_pick(bus_lv1_lv2_req_snoop & ~gnt_proc_q, snoop_ptr_q);
    assign owner_req  = |(bus_lv1_lv2_req_proc & gnt_proc_q);
    assign sub_req    = (state_q == SUB_SNOOP) ? |(bus_lv1_lv2_req_snoop & gnt_snoop_q)
                                               : bus_lv1_lv2_req_lv2;

`ifdef ARB_TIMEOUT_EN
    logic [TIMEOUT_WID-1:0] tmo_cnt_q;
    logic                   err_q;

    assign tmo_fire = (state_q != IDLE) && (tmo_cnt_q == TIMEOUT_WID'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (tmo_fire)
                err_q <= 1'b1;
            if (state_q == IDLE || state_d != state_q)
                tmo_cnt_q <= '0;
            else
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
    assign err_timeout = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0) ^ (TIMEOUT_WID > 0);
    assign tmo_fire       = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        gnt_lv2_d   = gnt_lv2_q;
        busy_d      = busy_q;
        rel_d       = rel_q;
        owner_d     = owner_q;
        proc_ptr_d  = proc_ptr_q;
        snoop_ptr_d = snoop_ptr_q;
        case (state_q)
            IDLE: begin
                if (proc_pick[CORE_ID_WID]) begin
                    gnt_proc_d = NUM_CORES'(1) << proc_pick[CORE_ID_WID-1:0];
                    owner_d    = proc_pick[CORE_ID_WID-1:0];
                    proc_ptr_d = proc_pick[CORE_ID_WID-1:0];
                    busy_d     = 1'b1;
                    state_d    = PROC;
                end
            end
            PROC: begin
                if (!owner_req) begin
                    gnt_proc_d = '0;
                    owner_d    = '0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (snoop_pick[CORE_ID_WID]) begin
                    gnt_snoop_d = NUM_CORES'(1) << snoop_pick[CORE_ID_WID-1:0];
                    snoop_ptr_d = snoop_pick[CORE_ID_WID-1:0];
                    state_d     = SUB_SNOOP;
                end else if (bus_lv1_lv2_req_lv2) begin
                    gnt_lv2_d = 1'b1;
                    state_d   = SUB_LV2;
                end
            end
            SUB_SNOOP, SUB_LV2: begin
                // An owner release during a sub-grant is remembered and honoured when the sub-grant ends.
                if (!owner_req)
                    rel_d = 1'b1;
                if (!sub_req) begin
                    gnt_snoop_d = '0;
                    gnt_lv2_d   = 1'b0;
                    rel_d       = 1'b0;
                    if (rel_q || !owner_req) begin
                        gnt_proc_d = '0;
                        owner_d    = '0;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = PROC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_fire) begin
            gnt_proc_d  = '0;
            gnt_snoop_d = '0;
            gnt_lv2_d   = 1'b0;
            busy_d      = 1'b0;
            rel_d       = 1'b0;
            owner_d     = '0;
            proc_ptr_d  = owner_q;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_lv2_q   <= 1'b0;
            busy_q      <= 1'b0;
            rel_q       <= 1'b0;
            owner_q     <= '0;
            proc_ptr_q  <= CORE_ID_WID'(NUM_CORES - 1);
            snoop_ptr_q <= CORE_ID_WID'(NUM_CORES - 1);
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            gnt_lv2_q   <= gnt_lv2_d;
            busy_q      <= busy_d;
            rel_q       <= rel_d;
            owner_q     <= owner_d;
            proc_ptr_q  <= proc_ptr_d;
            snoop_ptr_q <= snoop_ptr_d;
        end
    end

    assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
    assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
    assign bus_lv1_lv2_gnt_lv2   = gnt_lv2_q;
    assign bus_busy              = busy_q;
    assign owner_id              = owner_q;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Directed bench for lv1_lv2_bus_arbiter: a 4-core instance for the main sequence and an 8-core instance for wide wrap-around.
module tb_lv1_lv2_bus_arbiter;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] req_proc = '0, req_snoop = '0, gnt_proc, gnt_snoop;
  logic       req_lv2 = 1'b0, gnt_lv2, busy, err;
  logic [1:0] owner, dbg_state;

  logic [7:0] req_proc8 = '0, req_snoop8 = '0, gnt_proc8, gnt_snoop8;
  logic       req_lv28 = 1'b0, gnt_lv28, busy8, err8;
  logic [2:0] owner8;
  logic [1:0] dbg_state8;

  logic       exp_err = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [12:0] exp_q[$];
  logic [20:0] exp8_q[$];
  string       tag_q[$];

  lv1_lv2_bus_arbiter #(.NUM_CORES(4), .CORE_ID_WID(2), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WID(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_lv1_lv2_req_proc(req_proc), .bus_lv1_lv2_gnt_proc(gnt_proc),
    .bus_lv1_lv2_req_snoop(req_snoop), .bus_lv1_lv2_gnt_snoop(gnt_snoop),
    .bus_lv1_lv2_req_lv2(req_lv2), .bus_lv1_lv2_gnt_lv2(gnt_lv2),
    .bus_busy(busy), .owner_id(owner), .err_timeout(err), .dbg_state_o(dbg_state)
  );

  lv1_lv2_bus_arbiter #(.NUM_CORES(8), .CORE_ID_WID(3), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WID(5)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .bus_lv1_lv2_req_proc(req_proc8), .bus_lv1_lv2_gnt_proc(gnt_proc8),
    .bus_lv1_lv2_req_snoop(req_snoop8), .bus_lv1_lv2_gnt_snoop(gnt_snoop8),
    .bus_lv1_lv2_req_lv2(req_lv28), .bus_lv1_lv2_gnt_lv2(gnt_lv28),
    .bus_busy(busy8), .owner_id(owner8), .err_timeout(err8), .dbg_state_o(dbg_state8)
  );

  always #5 clk = ~clk;

  task automatic check4();
    logic [12:0] obs, e_v;
    string tag;
    e_v = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {gnt_proc, gnt_snoop, gnt_lv2, busy, owner, err};
    checks++;
    assert (obs === e_v) else begin
      errors++;
      $error("FAIL %s observed gp/gs/gl/busy/own/err=%b expected=%b", tag, obs, e_v);
    end
  endtask

  task automatic check8();
    logic [20:0] obs, e_v;
    string tag;
    e_v = exp8_q.pop_front();
    tag = tag_q.pop_front();
    obs = {gnt_proc8, gnt_snoop8, gnt_lv28, busy8, owner8};
    checks++;
    assert (obs === e_v) else begin
      errors++;
      $error("FAIL %s observed gp/gs/gl/busy/own=%b expected=%b", tag, obs, e_v);
    end
  endtask

  task automatic step(input logic [3:0] rp, input logic [3:0] rs, input logic rl,
                      input logic [3:0] gp, input logic [3:0] gs, input logic gl,
                      input logic [1:0] own, input string tag);
    req_proc  = rp;
    req_snoop = rs;
    req_lv2   = rl;
    exp_q.push_back({gp, gs, gl, |gp, own, exp_err});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check4();
  endtask

  task automatic step8(input logic [7:0] rp, input logic [7:0] gp, input logic [2:0] own,
                       input string tag);
    req_proc8 = rp;
    exp8_q.push_back({gp, 8'h00, 1'b0, |gp, own});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check8();
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] oh;
    int c;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    tag_q.push_back("reset4");
    check4();
    exp8_q.push_back('0);
    tag_q.push_back("reset8");
    check8();
    rst_n = 1'b1;

    // Round robin across all four cores, each holding three cycles.
    for (int r = 0; r < 5; r++) begin
      c  = r % 4;
      oh = 4'(1 << c);
      for (int h = 0; h < 3; h++) step(4'hF, 4'h0, 1'b0, oh, 4'h0, 1'b0, 2'(c), "rr_grant");
      step(4'hF & ~oh, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, "rr_release");
    end

    // Core 2 owns; snoops served round robin with its own bit masked, then L2.
    step(4'b0100, 4'h0, 1'b0, 4'b0100, 4'h0, 1'b0, 2'd2, "own2_grant");
    step(4'b0100, 4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b0, 2'd2, "snoop0_grant");
    step(4'b0100, 4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b0, 2'd2, "snoop0_hold");
    step(4'b0100, 4'b1110, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, "snoop0_drop");
    step(4'b0100, 4'b1110, 1'b1, 4'b0100, 4'b0010, 1'b0, 2'd2, "snoop1_grant");
    step(4'b0100, 4'b1100, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, "snoop1_drop");
    step(4'b0100, 4'b1100, 1'b1, 4'b0100, 4'b1000, 1'b0, 2'd2, "snoop3_grant");
    step(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, "snoop3_drop");
    step(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, "lv2_grant");
    step(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, "lv2_hold");
    step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, "lv2_drop");
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, "own2_release");

    // Core 1 releases during an L2 sub-grant; both clear together.
    step(4'b0010, 4'h0, 1'b0, 4'b0010, 4'h0, 1'b0, 2'd1, "own1_grant");
    step(4'b0010, 4'h0, 1'b1, 4'b0010, 4'h0, 1'b1, 2'd1, "own1_lv2");
    step(4'b0000, 4'h0, 1'b1, 4'b0010, 4'h0, 1'b1, 2'd1, "own1_rel_held");
    step(4'b0000, 4'h0, 1'b1, 4'b0010, 4'h0, 1'b1, 2'd1, "own1_rel_held2");
    step(4'b0000, 4'h0, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd0, "own1_both_clear");

    // Asynchronous reset while a snoop sub-grant is active.
    step(4'b0001, 4'h0, 1'b0, 4'b0001, 4'h0, 1'b0, 2'd0, "own0_grant");
    step(4'b0001, 4'b0011, 1'b0, 4'b0001, 4'b0010, 1'b0, 2'd0, "own0_snoop1");
    req_proc  = '0;
    req_snoop = '0;
    rst_n     = 1'b0;
    #2;
    exp_err = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("reset_async");
    check4();
    rst_n = 1'b1;
    step(4'b1000, 4'h0, 1'b0, 4'b1000, 4'h0, 1'b0, 2'd3, "post_reset_grant3");
    step(4'b0000, 4'h0, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd0, "post_reset_idle");

    // Eight cores: wrap-around from core 0 to core 7.
    step8(8'h81, 8'h01, 3'd0, "n8_grant0");
    step8(8'h80, 8'h00, 3'd0, "n8_release0");
    step8(8'h80, 8'h80, 3'd7, "n8_grant7");
    step8(8'h00, 8'h00, 3'd0, "n8_release7");

`ifdef ARB_TIMEOUT_EN
    // Stuck owner is cut off after TMO cycles and loses priority.
    step(4'b0001, 4'h0, 1'b0, 4'b0001, 4'h0, 1'b0, 2'd0, "tmo_grant");
    for (int h = 0; h < TMO - 1; h++) step(4'b0001, 4'h0, 1'b0, 4'b0001, 4'h0, 1'b0, 2'd0, "tmo_hold");
    exp_err = 1'b1;
    step(4'b0001, 4'h0, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd0, "tmo_fire");
    step(4'b0011, 4'h0, 1'b0, 4'b0010, 4'h0, 1'b0, 2'd1, "tmo_next_core1");
    step(4'b0000, 4'h0, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd0, "tmo_sticky");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
